// File: rtl/key_led_pkg.sv
// Purpose: shared mode encodings, default timing constants and the mode-advance helper for the key/LED controller.
// Latency: none (declarations only).
// Backpressure: none.
package key_led_pkg;

  // Mode encodings exactly as driven on the 2-bit mode output.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_t;

  // Defaults for a 50 MHz board clock.
  localparam int DB_CNT_MAX_DEF   = 999_999;     // 20 ms hold
  localparam int SLOW_CNT_MAX_DEF = 24_999_999;  // 0.5 s half-period
  localparam int FAST_CNT_MAX_DEF = 4_999_999;   // 0.1 s half-period
  localparam int CNT_W_DEF        = 25;

  // One step around the ring OFF -> ON -> SLOW -> FAST -> OFF.
  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_OFF:  next_mode = MODE_ON;
      MODE_ON:   next_mode = MODE_SLOW;
      MODE_SLOW: next_mode = MODE_FAST;
      default:   next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise and debounce an active-low key; one-cycle strobe per debounced press.
// Latency: press_pulse rises DB_CNT_MAX+3 edges after key_in is first sampled low.
// Backpressure: none; free-running, the strobe is never held.
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst     asynchronous active-high reset
//   key_in      raw key pin, asynchronous, 0 = pressed
//   key_stable  debounced key level, 1 = released
//   press_pulse one-cycle strobe on each debounced 1->0 transition
module key_debounce #(
  parameter int DB_CNT_MAX = 999_999,
  parameter int CNT_W      = 25
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CNT_MAX);

  logic             sync_a;
  logic             key_s;
  logic             stable_d;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_a      <= 1'b1;
      key_s       <= 1'b1;
      key_stable  <= 1'b1;
      stable_d    <= 1'b1;
      db_cnt      <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_a <= key_in;
      key_s  <= sync_a;

      // Any return to the accepted level restarts the hold window, so a
      // bounce shorter than DB_CNT_MAX+1 cycles never gets through.
      if (key_s == key_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        key_stable <= key_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // Falling edge of the debounced level only; release gives no strobe.
      stable_d    <= key_stable;
      press_pulse <= stable_d & ~key_stable;
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Purpose: step LED mode OFF/ON/BLINK_SLOW/BLINK_FAST on each debounced key press and drive the LED.
// Latency: mode updates 1 edge after press_pulse; led_out follows mode/phase 1 edge later.
// Backpressure: none; every press_pulse is consumed in the cycle it appears.
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst     asynchronous active-high reset
//   key_in      raw key pin, 0 = pressed
//   led_out     registered LED drive, 1 = lit
//   mode        current mode: 00 OFF, 01 ON, 10 BLINK_SLOW, 11 BLINK_FAST
//   press_pulse one-cycle strobe per debounced press
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int DB_CNT_MAX   = DB_CNT_MAX_DEF,
  parameter int SLOW_CNT_MAX = SLOW_CNT_MAX_DEF,
  parameter int FAST_CNT_MAX = FAST_CNT_MAX_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       press_pulse
);

  localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(SLOW_CNT_MAX);
  localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(FAST_CNT_MAX);

  mode_t            state;
  logic [CNT_W-1:0] blink_cnt;
  logic [CNT_W-1:0] blink_max;
  logic             phase;
  // Debounced level is not needed here; kept named for probing.
  logic             key_level_unused;

  key_debounce #(
    .DB_CNT_MAX (DB_CNT_MAX),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_stable  (key_level_unused),
    .press_pulse (press_pulse)
  );

  assign mode = state;

  always_comb begin
    blink_max = SLOW_MAX;
    if (state == MODE_FAST) blink_max = FAST_MAX;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= MODE_OFF;
      blink_cnt <= '0;
      phase     <= 1'b0;
      led_out   <= 1'b0;
    end else begin
      // A press takes priority over a coincident blink wrap so every new
      // mode starts from a fresh, lit half-period.
      if (press_pulse) begin
        state     <= next_mode(state);
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (state == MODE_SLOW || state == MODE_FAST) begin
        if (blink_cnt == blink_max) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
      end

      case (state)
        MODE_OFF: led_out <= 1'b0;
        MODE_ON:  led_out <= 1'b1;
        default:  led_out <= phase;
      endcase
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Purpose: directed self-checking bench for key_led_ctrl with short debounce/blink counts.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_key_led_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_in  = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       press_pulse;

  int         total = 0;
  int         bad   = 0;

  // Expected state: current mode and edges since it was entered.
  logic [1:0] exp_mode = 2'b00;
  int         since_mc = 1;
  // Mode/age the LED still reflects on the edge where the mode changes.
  logic [1:0] pm = 2'b00;
  int         pn = 1;

  key_led_ctrl #(
    .DB_CNT_MAX   (3),
    .SLOW_CNT_MAX (7),
    .FAST_CNT_MAX (1),
    .CNT_W        (25)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .led_out     (led_out),
    .mode        (mode),
    .press_pulse (press_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  // LED after the n-th edge in a mode: SLOW lit for 8 edges then dark for 8,
  // FAST lit for 2 then dark for 2, starting lit.
  function automatic logic led_model(input logic [1:0] m, input int n);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return (((n - 1) / 8) % 2) == 0;
      default: return (((n - 1) / 2) % 2) == 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and check all outputs 1 ns after it.
  task automatic cycle(input logic exp_pulse);
    @(posedge sys_clk);
    #1;
    since_mc++;
    check("press_pulse", 32'(press_pulse), 32'(exp_pulse));
    check("mode", 32'(mode), 32'(exp_mode));
    if (since_mc == 0)
      check("led_on_mode_edge", 32'(led_out), 32'(led_model(pm, pn)));
    else
      check("led", 32'(led_out), 32'(led_model(exp_mode, since_mc)));
  endtask

  // Clean press: low for 10 edges (e=0..9), then released; pulse after edge 6,
  // mode change at edge 7, no pulse on release.
  task automatic do_press(input logic [1:0] next);
    key_in = 1'b0;
    for (int e = 0; e < 20; e++) begin
      if (e == 7) begin
        pm       = exp_mode;
        pn       = since_mc + 1;
        exp_mode = next;
        since_mc = -1;
      end
      cycle(e == 6);
      if (e == 9) key_in = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    exp_mode = 2'b00;
    since_mc = 1;
  endtask

  initial begin
    // 1: reset state, then long idle with the key released.
    #12;
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_pulse", 32'(press_pulse), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle(1'b0);

    // 2: single held press, then release.
    do_press(2'b01);
    check("t2_led_on", 32'(led_out), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0);

    // 3: bounce of 3 low / 2 high / 3 low never completes the 4-cycle hold.
    do_reset();
    key_in = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    key_in = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0);
    key_in = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    key_in = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b0);
    check("t3_mode_off", 32'(mode), 32'd0);

    // 4: walk the full ring with blink periods checked along the way.
    do_reset();
    do_press(2'b01);
    do_press(2'b10);
    for (int i = 0; i < 20; i++) cycle(1'b0);
    do_press(2'b11);
    for (int i = 0; i < 8; i++) cycle(1'b0);
    do_press(2'b00);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check("t4_led_off", 32'(led_out), 32'd0);

    // 5: async reset between edges while BLINK_SLOW has the LED lit.
    do_reset();
    do_press(2'b01);
    do_press(2'b10);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check("t5_led_lit_before", 32'(led_out), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("t5_async_led", 32'(led_out), 32'd0);
    check("t5_async_mode", 32'(mode), 32'd0);
    check("t5_async_pulse", 32'(press_pulse), 32'd0);
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    exp_mode = 2'b00;
    since_mc = 1;
    do_press(2'b01);

    // 6: press lands on the SLOW wrap edge (edge 24 of the mode); the mode
    // change must win and FAST must start lit with no extra toggle.
    do_press(2'b10);
    for (int i = 0; i < 4; i++) cycle(1'b0);
    do_press(2'b11);
    for (int i = 0; i < 6; i++) cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
